// File: rtl/window_pixel_fetch_pkg.sv
// Shared image geometry, pixel types and address helper for the window pixel fetch slice.
package window_pixel_fetch_pkg;

    localparam int IMG_WIDTH  = 320;
    localparam int IMG_HEIGHT = 240;
    localparam int W_PIX      = 8;
    localparam int W_X        = $clog2(IMG_WIDTH);
    localparam int W_Y        = $clog2(IMG_HEIGHT);
    localparam int W_MEM_ADDR = $clog2(IMG_WIDTH * IMG_HEIGHT);

    typedef struct packed {
        logic [W_PIX-1:0] data;
        logic             last;
    } pix_t;

    // Out-of-range coordinates clamp to the image edge so the address never wraps.
    function automatic logic [W_MEM_ADDR-1:0] linear_addr(input logic [W_X-1:0] x, input logic [W_Y-1:0] y);
        logic [W_X-1:0] xs;
        logic [W_Y-1:0] ys;
        xs = (x > W_X'(IMG_WIDTH - 1))  ? W_X'(IMG_WIDTH - 1)  : x;
        ys = (y > W_Y'(IMG_HEIGHT - 1)) ? W_Y'(IMG_HEIGHT - 1) : y;
        return (W_MEM_ADDR'(ys) * W_MEM_ADDR'(IMG_WIDTH)) + W_MEM_ADDR'(xs);
    endfunction

endpackage

// File: rtl/window_pixel_fetch_if.sv
// Sweeper address stream, image RAM read port and pixel output stream of the fetch block.
import window_pixel_fetch_pkg::*;

interface window_pixel_fetch_if;
    logic                  addr_valid;
    logic                  addr_ready;
    logic [W_X-1:0]        x;
    logic [W_Y-1:0]        y;
    logic                  mem_rd_en;
    logic [W_MEM_ADDR-1:0] mem_addr;
    logic [W_PIX-1:0]      mem_rd_data;
    logic                  pix_valid;
    logic                  pix_ready;
    logic [W_PIX-1:0]      pix_data;
    logic                  pix_last;

    modport slave (
        input  addr_valid, x, y, mem_rd_data, pix_ready,
        output addr_ready, mem_rd_en, mem_addr, pix_valid, pix_data, pix_last
    );

    modport master (
        output addr_valid, x, y, mem_rd_data, pix_ready,
        input  addr_ready, mem_rd_en, mem_addr, pix_valid, pix_data, pix_last
    );
endinterface

// File: rtl/window_pixel_fetch_chk.sv
// Protocol checks for the fetch block's output buffer.
module window_pixel_fetch_chk (
    input logic clk,
    input logic rst,
    input logic push,
    input logic full
);

    a_no_push_on_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/window_pixel_fetch_pix_fifo.sv
// Shift-style synchronous FIFO of pix_t; the head entry is a register so dout is registered.
import window_pixel_fetch_pkg::*;

module window_pixel_fetch_pix_fifo #(
    parameter  int DEPTH = 4,
    localparam int W_CNT = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  pix_t             din,
    input  logic             pop,
    output pix_t             dout,
    output logic             full,
    output logic             empty,
    output logic [W_CNT-1:0] count
);

    pix_t             data_r     [DEPTH];
    pix_t             shift_s    [DEPTH];
    pix_t             data_nxt_s [DEPTH];
    logic [W_CNT-1:0] count_r;
    logic [W_CNT-1:0] count_nxt_s;
    logic [W_CNT-1:0] wr_idx_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty     = (count_r == W_CNT'(0));
    assign full      = (count_r == W_CNT'(DEPTH));
    assign count     = count_r;
    assign dout      = data_r[0];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Next storage image: shift towards the head on pop, then drop the new entry behind the last valid one.
    always_comb begin
        wr_idx_s = pop_ok_s ? (count_r - W_CNT'(1)) : count_r;
        for (int i = 0; i < DEPTH - 1; i++) begin
            shift_s[i] = pop_ok_s ? data_r[i+1] : data_r[i];
        end
        shift_s[DEPTH-1] = pop_ok_s ? '0 : data_r[DEPTH-1];
        for (int i = 0; i < DEPTH; i++) begin
            data_nxt_s[i] = (push_ok_s && (wr_idx_s == W_CNT'(i))) ? din : shift_s[i];
        end
    end

    // Occupancy update; simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + W_CNT'(1);
            2'b01:   count_nxt_s = count_r - W_CNT'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= '0;
            end
        end else begin
            count_r <= count_nxt_s;
            data_r  <= data_nxt_s;
        end
    end

endmodule

// File: rtl/window_pixel_fetch.sv
// Turns sweeper (x,y) addresses into image RAM reads and streams the returned pixels with a window-last tag.
import window_pixel_fetch_pkg::*;

module window_pixel_fetch #(
    parameter int FEATURE_WIDTH  = 25,
    parameter int FEATURE_HEIGHT = 25,
    parameter int MEM_LATENCY    = 1,
    parameter int FIFO_DEPTH     = 4
) (
    input logic                  clk,
    input logic                  rst,
    window_pixel_fetch_if.slave  bus
);

    localparam int WIN_PIX = FEATURE_WIDTH * FEATURE_HEIGHT;
    localparam int W_PC    = $clog2(WIN_PIX);
    localparam int W_CNT   = $clog2(FIFO_DEPTH) + 1;

    logic [MEM_LATENCY-1:0] vld_sr_r;
    logic [W_CNT-1:0]       inflight_r;
    logic [W_CNT-1:0]       inflight_nxt_s;
    logic [W_CNT-1:0]       fifo_count_s;
    logic [W_PC-1:0]        pix_cnt_r;
    logic                   hs_s;
    logic                   tail_s;
    logic                   push_last_s;
    logic                   pop_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    pix_t                   fifo_din_s;
    pix_t                   fifo_dout_s;

    // Credits count every accepted read not yet handed downstream, so the FIFO can never overflow.
    assign bus.addr_ready = !rst && ((inflight_r + fifo_count_s) < W_CNT'(FIFO_DEPTH));
    assign hs_s           = bus.addr_valid && bus.addr_ready;
    assign bus.mem_rd_en  = hs_s;
    assign bus.mem_addr   = linear_addr(bus.x, bus.y);

    assign tail_s      = vld_sr_r[MEM_LATENCY-1];
    assign push_last_s = (pix_cnt_r == W_PC'(WIN_PIX - 1));
    assign fifo_din_s  = '{data: bus.mem_rd_data, last: push_last_s};
    assign pop_s       = bus.pix_valid && bus.pix_ready;

    assign bus.pix_valid = !fifo_empty_s;
    assign bus.pix_data  = fifo_dout_s.data;
    assign bus.pix_last  = fifo_dout_s.last;

    // In-flight count tracks the ones in the latency shift register.
    always_comb begin
        inflight_nxt_s = inflight_r;
        case ({hs_s, tail_s})
            2'b10:   inflight_nxt_s = inflight_r + W_CNT'(1);
            2'b01:   inflight_nxt_s = inflight_r - W_CNT'(1);
            default: inflight_nxt_s = inflight_r;
        endcase
    end

    // Read-return shift register, in-flight counter and window pixel counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr_r   <= '0;
            inflight_r <= '0;
            pix_cnt_r  <= '0;
        end else begin
            vld_sr_r[0] <= hs_s;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                vld_sr_r[i] <= vld_sr_r[i-1];
            end
            inflight_r <= inflight_nxt_s;
            if (tail_s) begin
                pix_cnt_r <= push_last_s ? W_PC'(0) : (pix_cnt_r + W_PC'(1));
            end else begin
                pix_cnt_r <= pix_cnt_r;
            end
        end
    end

    window_pixel_fetch_pix_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tail_s),
        .din   (fifo_din_s),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    window_pixel_fetch_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .push (tail_s),
        .full (fifo_full_s)
    );

endmodule
